link_sync_ctrl: RTL and testbench
=================================

# link_sync_ctrl

Receive-side link synchronization controller for the 8b/10b datapath. It watches raw 10-bit symbols and the registered outputs of the 8b/10b decoder (data, K flag, code/disparity errors). It runs a comma-based acquire/lose-sync state machine, requests bit-slips from the deserializer while unaligned, and gates decoded data to the downstream link layer only while in sync.

## Interface
Parameters:
- ACQ_COMMAS, 3: error-free commas needed in a row to declare sync.
- GOOD_CNT_MAX, 4: consecutive good symbols that clear one error level.
- ERR_MAX, 4: error level that forces loss of sync.
- SLIP_TIMEOUT, 20: valid symbols without a comma in LOS before a bit-slip is requested.
- SLIP_BLANK, 2: valid symbols ignored after each bit-slip.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- sym_valid  in  1  rx_sym valid this cycle.
- rx_sym  in  10  raw symbol {a,b,c,d,e,i,f,g,h,j}, with a at bit 9.
- dec_data  in  8  decoder output {HGF,EDCBA}, one cycle after rx_sym.
- dec_kout  in  1  decoder K flag (6b and 4b K both set), one cycle after rx_sym.
- dec_code_err  in  1  OR of the 6b and 4b code errors, one cycle after rx_sym.
- dec_disp_err  in  1  running-disparity error, one cycle after rx_sym.
- bitslip  out  1  one-cycle slip request to the deserializer.
- sync_ok  out  1  link synchronized.
- dout_valid  out  1  dout/kout valid.
- dout  out  8  gated decoded byte.
- kout  out  1  gated K flag.
- err_cnt  out  16  saturating error count (see Configuration).
- los_cnt  out  8  saturating sync-loss count (see Configuration).

## Operation
- Comma: rx_sym[9:3] equals 7'b0011111 or 7'b1100000. It is registered with sym_valid to form comma_d and valid_d, which pair with the dec_* inputs of the same cycle.
- All decisions are taken only in cycles where valid_d=1.
- A symbol is bad when dec_code_err or dec_disp_err is set; otherwise it is good.
- States:
  - LOS (reset state).
  - ACQ: cnt counts commas.
  - SYNC.
  - SYNC_ERR: lvl is the error level, good is the good-symbol count.
- LOS:
  - Good comma: go to ACQ with cnt=1 and clear the slip timer.
  - Any other valid symbol: increment the slip timer.
  - Slip timer reaches SLIP_TIMEOUT: pulse bitslip, clear the timer, and ignore the next SLIP_BLANK valid symbols. Ignored symbols do not count toward the timer.
- ACQ:
  - Bad symbol: go to LOS.
  - Good comma: cnt+1. When cnt reaches ACQ_COMMAS, go to SYNC.
  - Good non-comma: stay.
- SYNC:
  - Bad symbol: go to SYNC_ERR with lvl=1, good=0.
- SYNC_ERR:
  - Bad symbol: lvl+1, good=0. When lvl reaches ERR_MAX, go to LOS.
  - Good symbol: good+1. When good reaches GOOD_CNT_MAX, lvl-1 and good=0. When lvl reaches 0, go to SYNC.
- Outputs:
  - sync_ok=1 in SYNC and SYNC_ERR.
  - dout_valid=valid_d while in SYNC or SYNC_ERR (state before update), including bad symbols.
  - dout/kout pass through; they are forced to 0 on bad symbols or when not in sync.
- Any entry into LOS clears the cnt, lvl, good and slip-timer counters.

## Timing
- Reset values: state LOS; bitslip, sync_ok, dout_valid, kout = 0; dout = 0; err_cnt, los_cnt = 0; all internal counters = 0.
- Latency: rx_sym in cycle t, dec_* in cycle t+1; state and all outputs are registered and visible in cycle t+2.
- bitslip is exactly one cycle wide, driven in the cycle after the timeout symbol is evaluated. A new request is never raised during blanking.
- Back-to-back valid symbols are supported. Gaps (sym_valid=0) freeze every counter and the state.
- A comma that is also bad counts as bad.
- In SYNC_ERR, a bad symbol is applied before the lvl check.
- Asynchronous reset mid-operation returns to LOS immediately; a pending blank is discarded.

## Configuration
- SYNC_STATS_EN defined:
  - err_cnt increments on each evaluated bad symbol in any state and saturates at 16'hFFFF.
  - los_cnt increments on each SYNC/SYNC_ERR to LOS transition and saturates at 8'hFF.
- SYNC_STATS_EN undefined: both ports exist and are tied to 0, and no counter flops are synthesized.

## Structure
- Package link_sync_pkg holds:
  - the state enum;
  - COMMA_P = 7'b0011111 and COMMA_N = 7'b1100000;
  - K28_5 = 8'hBC.
- Sub-module comma_det holds the registered comma detector (rx_sym, sym_valid in; comma_d, valid_d out). The top holds the FSM, counters and output gating.

## Test plan
- 3 clean K28.5 (0011111010), then D-data: sync_ok rises 2 cycles after the third comma is presented; dout_valid follows; bytes pass unchanged.
- Garbage for 20 valid symbols in LOS: one bitslip pulse; the next 2 symbols are ignored; the timer restarts; no second pulse before 20 further symbols.
- In SYNC, 1 code error then 4 good symbols: SYNC_ERR lvl=1, then back to SYNC; sync_ok stays 1; the errored byte is output as dout=0 with dout_valid=1.
- In SYNC, 4 code errors with 3 good symbols between each: sync_ok drops after the 4th error; los_cnt=1 with SYNC_EN (SYNC_STATS_EN) defined.
- In ACQ after 2 commas, a disparity error: return to LOS with cnt cleared; 3 further commas are needed.
- reset_n pulsed low in SYNC_ERR with sym_valid gaps: all outputs are 0 immediately, the state is LOS, and err_cnt=0.

Source files
------------

// File: rtl/link_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_sync_pkg
// Description : Shared types and constants for the receive-side link
//               synchronization controller: FSM state encoding, the 7-bit
//               comma patterns, the K28.5 byte value and a counter-width
//               helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package link_sync_pkg;

  typedef enum logic [1:0] {
    ST_LOS      = 2'd0,
    ST_ACQ      = 2'd1,
    ST_SYNC     = 2'd2,
    ST_SYNC_ERR = 2'd3
  } sync_state_e;

  // Comma prefixes {a,b,c,d,e,i,f} for both running disparities
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  localparam logic [7:0] K28_5 = 8'hBC;

  // Width of a counter that must hold values 0..max_val (never zero-width)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic is_comma(input logic [9:0] sym);
    return (sym[9:3] == COMMA_P) || (sym[9:3] == COMMA_N);
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_sync_ctrl_comma_det.sv
`default_nettype none
// ============================================================================
// Module      : comma_det
// Description : Registered comma detector. Delays sym_valid by one cycle and
//               flags a comma in the same cycle, so both line up with the
//               decoder outputs for that symbol.
// Ports       : clk       - clock
//               reset_n   - asynchronous active-low reset
//               sym_valid - raw symbol valid
//               rx_sym    - raw 10-bit symbol, bit 9 = a
//               comma_d   - registered comma flag (only set when valid)
//               valid_d   - registered symbol valid
// Revision    : 1.0 - initial release
// ============================================================================
module comma_det
  import link_sync_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sym_valid,
  input  logic [9:0] rx_sym,
  output logic       comma_d,
  output logic       valid_d
);

  logic comma_q;
  logic valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      comma_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sym_valid;
      comma_q <= sym_valid & is_comma(rx_sym);
    end
  end

  assign comma_d = comma_q;
  assign valid_d = valid_q;

endmodule
`default_nettype wire

// File: rtl/link_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : link_sync_ctrl
// Description : Receive-side 8b/10b link synchronization controller. Runs the
//               comma-based acquire / lose-sync FSM, requests bit-slips while
//               unaligned and gates decoded bytes to the link layer while in
//               sync. Optional statistics counters are enabled with the
//               SYNC_STATS_EN macro; otherwise err_cnt/los_cnt read 0.
// Ports       : clk, reset_n (async active-low)
//               sym_valid, rx_sym          - raw symbol stream
//               dec_data, dec_kout,
//               dec_code_err, dec_disp_err - decoder outputs, 1 cycle later
//               bitslip                    - one-cycle slip request
//               sync_ok                    - link synchronized
//               dout_valid, dout, kout     - gated decoded output
//               err_cnt, los_cnt           - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module link_sync_ctrl
  import link_sync_pkg::*;
#(
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CNT_MAX = 4,
  parameter int ERR_MAX      = 4,
  parameter int SLIP_TIMEOUT = 20,
  parameter int SLIP_BLANK   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sym_valid,
  input  logic [9:0]  rx_sym,
  input  logic [7:0]  dec_data,
  input  logic        dec_kout,
  input  logic        dec_code_err,
  input  logic        dec_disp_err,
  output logic        bitslip,
  output logic        sync_ok,
  output logic        dout_valid,
  output logic [7:0]  dout,
  output logic        kout,
  output logic [15:0] err_cnt,
  output logic [7:0]  los_cnt
);

  localparam int c_cnt_w  = cnt_width(ACQ_COMMAS);
  localparam int c_good_w = cnt_width(GOOD_CNT_MAX);
  localparam int c_lvl_w  = cnt_width(ERR_MAX);
  localparam int c_tmr_w  = cnt_width(SLIP_TIMEOUT);
  localparam int c_blk_w  = cnt_width(SLIP_BLANK);

  // "Last" values: the counter is at its limit once this value is incremented
  localparam logic [c_cnt_w-1:0]  c_acq_last  = c_cnt_w'(ACQ_COMMAS - 1);
  localparam logic [c_good_w-1:0] c_good_last = c_good_w'(GOOD_CNT_MAX - 1);
  localparam logic [c_lvl_w-1:0]  c_err_last  = c_lvl_w'(ERR_MAX - 1);
  localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'(SLIP_TIMEOUT - 1);
  localparam logic [c_blk_w-1:0]  c_blank     = c_blk_w'(SLIP_BLANK);

  logic comma_d;
  logic valid_d;

  comma_det u_comma_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .sym_valid (sym_valid),
    .rx_sym    (rx_sym),
    .comma_d   (comma_d),
    .valid_d   (valid_d)
  );

  sync_state_e         state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
  logic [c_lvl_w-1:0]  lvl_q,   lvl_d;
  logic [c_good_w-1:0] good_q,  good_d;
  logic [c_tmr_w-1:0]  tmr_q,   tmr_d;
  logic [c_blk_w-1:0]  blank_q, blank_d;
  logic                slip_d;
  logic                go_los;

  logic bad;
  logic in_sync;
  logic pass;

  assign bad     = dec_code_err | dec_disp_err;
  assign in_sync = (state_q == ST_SYNC) || (state_q == ST_SYNC_ERR);
  assign pass    = valid_d & in_sync & ~bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    good_d  = good_q;
    tmr_d   = tmr_q;
    blank_d = blank_q;
    slip_d  = 1'b0;
    go_los  = 1'b0;

    if (valid_d) begin
      unique case (state_q)
        ST_LOS: begin
          // Symbols right after a slip are discarded: the deserializer
          // output is not yet trustworthy and they must not touch the timer.
          if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
          end else if (comma_d && !bad) begin
            tmr_d = '0;
            if (ACQ_COMMAS <= 1) begin
              state_d = ST_SYNC;
            end else begin
              state_d = ST_ACQ;
              cnt_d   = c_cnt_w'(1);
            end
          end else if (tmr_q == c_tmr_last) begin
            slip_d  = 1'b1;
            tmr_d   = '0;
            blank_d = c_blank;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end

        ST_ACQ: begin
          if (bad) begin
            go_los = 1'b1;
          end else if (comma_d) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_acq_last) state_d = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (bad) begin
            if (ERR_MAX <= 1) begin
              go_los = 1'b1;
            end else begin
              state_d = ST_SYNC_ERR;
              lvl_d   = c_lvl_w'(1);
              good_d  = '0;
            end
          end
        end

        ST_SYNC_ERR: begin
          if (bad) begin
            lvl_d  = lvl_q + 1'b1;
            good_d = '0;
            if (lvl_q == c_err_last) go_los = 1'b1;
          end else if (good_q == c_good_last) begin
            good_d = '0;
            lvl_d  = lvl_q - 1'b1;
            if (lvl_q == c_lvl_w'(1)) state_d = ST_SYNC;
          end else begin
            good_d = good_q + 1'b1;
          end
        end

        default: go_los = 1'b1;
      endcase

      if (go_los) begin
        state_d = ST_LOS;
        cnt_d   = '0;
        lvl_d   = '0;
        good_d  = '0;
        tmr_d   = '0;
        blank_d = '0;
      end
    end
  end

  logic       bitslip_q;
  logic       sync_ok_q;
  logic       dout_valid_q;
  logic [7:0] dout_q;
  logic       kout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LOS;
      cnt_q        <= '0;
      lvl_q        <= '0;
      good_q       <= '0;
      tmr_q        <= '0;
      blank_q      <= '0;
      bitslip_q    <= 1'b0;
      sync_ok_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= 8'h00;
      kout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lvl_q        <= lvl_d;
      good_q       <= good_d;
      tmr_q        <= tmr_d;
      blank_q      <= blank_d;
      bitslip_q    <= slip_d;
      sync_ok_q    <= (state_d == ST_SYNC) || (state_d == ST_SYNC_ERR);
      // Output qualification uses the state before this symbol's update
      dout_valid_q <= valid_d & in_sync;
      dout_q       <= pass ? dec_data : 8'h00;
      kout_q       <= pass & dec_kout;
    end
  end

  assign bitslip    = bitslip_q;
  assign sync_ok    = sync_ok_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign kout       = kout_q;

`ifdef SYNC_STATS_EN
  logic [15:0] err_cnt_q;
  logic [7:0]  los_cnt_q;
  logic        err_ev;
  logic        los_ev;

  // Blanked symbols are discarded, so they are not counted as errors either
  assign err_ev = valid_d & bad & ~((state_q == ST_LOS) && (blank_q != '0));
  assign los_ev = valid_d & in_sync & (state_d == ST_LOS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 16'h0000;
      los_cnt_q <= 8'h00;
    end else begin
      if (err_ev && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (los_ev && (los_cnt_q != 8'hFF))    los_cnt_q <= los_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
  assign los_cnt = los_cnt_q;
`else
  assign err_cnt = 16'h0000;
  assign los_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_sync_ctrl
// Description : Self-checking bench for link_sync_ctrl. Each drive() call
//               presents one raw symbol and, one cycle later, its decoder
//               outputs; bytes expected at dout are queued when driven and
//               compared in order whenever dout_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_sync_ctrl;
  import link_sync_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sym_valid = 1'b0;
  logic [9:0]  rx_sym = '0;
  logic [7:0]  dec_data = '0;
  logic        dec_kout = 1'b0;
  logic        dec_code_err = 1'b0;
  logic        dec_disp_err = 1'b0;
  logic        bitslip;
  logic        sync_ok;
  logic        dout_valid;
  logic [7:0]  dout;
  logic        kout;
  logic [15:0] err_cnt;
  logic [7:0]  los_cnt;

  localparam logic [9:0] SYM_K285 = 10'b0011111010;
  localparam logic [9:0] SYM_DATA = 10'b1010101010;
  localparam logic [9:0] SYM_JUNK = 10'b1101000110;

`ifdef SYNC_STATS_EN
  localparam int EXP_ERRS = 5;
  localparam int EXP_LOSS = 1;
`else
  localparam int EXP_ERRS = 0;
  localparam int EXP_LOSS = 0;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int slip_cnt = 0;
  logic [8:0] exp_q[$];

  // Decoder fields of the symbol driven last cycle
  logic [7:0] p_d  = '0;
  logic       p_k  = 1'b0;
  logic       p_ce = 1'b0;
  logic       p_de = 1'b0;

  always #5 clk = ~clk;

  link_sync_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sym_valid    (sym_valid),
    .rx_sym       (rx_sym),
    .dec_data     (dec_data),
    .dec_kout     (dec_kout),
    .dec_code_err (dec_code_err),
    .dec_disp_err (dec_disp_err),
    .bitslip      (bitslip),
    .sync_ok      (sync_ok),
    .dout_valid   (dout_valid),
    .dout         (dout),
    .kout         (kout),
    .err_cnt      (err_cnt),
    .los_cnt      (los_cnt)
  );

  // One clock of stimulus plus scoreboard pop at the following negedge
  task automatic drive(input logic v, input logic [9:0] s, input logic [7:0] d,
                       input logic k, input logic ce, input logic de,
                       input logic expect_out);
    logic [8:0] e;
    @(posedge clk); #1;
    sym_valid    = v;
    rx_sym       = s;
    dec_data     = p_d;
    dec_kout     = p_k;
    dec_code_err = p_ce;
    dec_disp_err = p_de;
    p_d  = v ? d  : 8'h00;
    p_k  = v ? k  : 1'b0;
    p_ce = v ? ce : 1'b0;
    p_de = v ? de : 1'b0;
    if (v && expect_out) exp_q.push_back((ce || de) ? 9'h000 : {k, d});
    @(negedge clk);
    if (bitslip === 1'b1) slip_cnt++;
    if (dout_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got dout_valid=1 dout=%h kout=%b, required no output", dout, kout);
      end else begin
        e = exp_q.pop_front();
        if ({kout, dout} !== e) begin
          n_bad++;
          $display("FAIL sb_data: got kout=%b dout=%h, required kout=%b dout=%h", kout, dout, e[8], e[7:0]);
        end
      end
    end
  endtask

  task automatic comma(input logic expect_out);
    drive(1'b1, SYM_K285, K28_5, 1'b1, 1'b0, 1'b0, expect_out);
  endtask

  task automatic data(input logic [7:0] d, input logic expect_out);
    drive(1'b1, SYM_DATA, d, 1'b0, 1'b0, 1'b0, expect_out);
  endtask

  task automatic code_err(input logic expect_out);
    drive(1'b1, SYM_DATA, 8'h5C, 1'b0, 1'b1, 1'b0, expect_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    sym_valid = 1'b0;
    rx_sym = '0;
    dec_data = '0; dec_kout = 1'b0; dec_code_err = 1'b0; dec_disp_err = 1'b0;
    p_d = '0; p_k = 1'b0; p_ce = 1'b0; p_de = 1'b0;
    exp_q.delete();
    slip_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bitslip, sync_ok, dout_valid, kout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got bitslip,sync_ok,dout_valid,kout=%b, required 0000", {bitslip, sync_ok, dout_valid, kout});
    end
    n_total++;
    if (dout !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_dout: got %h, required 00", dout);
    end
    n_total++;
    if ({err_cnt, los_cnt} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_stats: got err_cnt=%0d los_cnt=%0d, required 0 0", err_cnt, los_cnt);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    idle(2);
    n_total++;
    if (sync_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_sync: got %b, required 0", sync_ok);
    end
  endtask

  task automatic test_acquire();
    logic [7:0] bytes [5] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h3C};
    do_reset();
    comma(1'b0); comma(1'b0); comma(1'b0);
    n_total++;
    if (sync_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL acq_sync_t0: got %b, required 0", sync_ok);
    end
    data(8'h81, 1'b1);
    n_total++;
    if (sync_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL acq_sync_t1: got %b, required 0", sync_ok);
    end
    data(8'h42, 1'b1);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL acq_sync_t2: got %b, required 1", sync_ok);
    end
    for (int i = 0; i < 5; i++) data(bytes[i], 1'b1);
    comma(1'b1);
    idle(3);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL acq_drain: got %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_slip();
    do_reset();
    for (int i = 0; i < 19; i++) drive(1'b1, SYM_JUNK, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    n_total++;
    if (slip_cnt != 0) begin
      n_bad++;
      $display("FAIL slip_early: got %0d pulses, required 0", slip_cnt);
    end
    drive(1'b1, SYM_JUNK, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    n_total++;
    if (slip_cnt != 1) begin
      n_bad++;
      $display("FAIL slip_first: got %0d pulse cycles, required 1", slip_cnt);
    end
    // Both blanked symbols are clean commas: they must be ignored entirely
    comma(1'b0); comma(1'b0);
    for (int i = 0; i < 19; i++) drive(1'b1, SYM_JUNK, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    n_total++;
    if ({slip_cnt == 1, sync_ok} !== 2'b10) begin
      n_bad++;
      $display("FAIL slip_blank: got pulses=%0d sync_ok=%b, required 1 0", slip_cnt, sync_ok);
    end
    drive(1'b1, SYM_JUNK, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    n_total++;
    if (slip_cnt != 2) begin
      n_bad++;
      $display("FAIL slip_second: got %0d pulse cycles, required 2", slip_cnt);
    end
  endtask

  task automatic test_err_recover();
    logic dropped = 1'b0;
    do_reset();
    comma(1'b0); comma(1'b0); comma(1'b0);
    idle(2);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL rec_sync: got %b, required 1", sync_ok);
    end
    data(8'h11, 1'b1);
    code_err(1'b1);
    if (sync_ok !== 1'b1) dropped = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data(8'h30 + 8'(i), 1'b1);
      if (sync_ok !== 1'b1) dropped = 1'b1;
    end
    idle(3);
    if (sync_ok !== 1'b1) dropped = 1'b1;
    n_total++;
    if (dropped !== 1'b0) begin
      n_bad++;
      $display("FAIL rec_stay: got sync drop=%b, required 0", dropped);
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rec_drain: got %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  // Runs straight after test_err_recover, so it relies on lvl having returned to 0
  task automatic test_lose_sync();
    for (int e = 0; e < 3; e++) begin
      code_err(1'b1);
      for (int g = 0; g < 3; g++) data(8'h60 + 8'(4 * e + g), 1'b1);
    end
    idle(2);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL los_before4: got %b, required 1", sync_ok);
    end
    code_err(1'b1);
    idle(1);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL los_t1: got %b, required 1", sync_ok);
    end
    idle(1);
    n_total++;
    if (sync_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL los_t2: got %b, required 0", sync_ok);
    end
    data(8'h77, 1'b0);
    data(8'h78, 1'b0);
    idle(3);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL los_drain: got %0d outputs missing, required 0", exp_q.size());
    end
    n_total++;
    if ({err_cnt, los_cnt} !== {16'(EXP_ERRS), 8'(EXP_LOSS)}) begin
      n_bad++;
      $display("FAIL los_stats: got err_cnt=%0d los_cnt=%0d, required %0d %0d", err_cnt, los_cnt, EXP_ERRS, EXP_LOSS);
    end
  endtask

  task automatic test_acq_abort();
    do_reset();
    comma(1'b0); comma(1'b0);
    drive(1'b1, SYM_K285, K28_5, 1'b1, 1'b0, 1'b1, 1'b0);
    comma(1'b0); comma(1'b0);
    idle(2);
    n_total++;
    if (sync_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_two: got %b, required 0", sync_ok);
    end
    comma(1'b0);
    idle(2);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_three: got %b, required 1", sync_ok);
    end
    data(8'hC3, 1'b1);
    data(8'h3C, 1'b1);
    idle(3);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_drain: got %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    comma(1'b0); comma(1'b0); comma(1'b0);
    idle(2);
    code_err(1'b1);
    idle(3);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: got %b, required 1", sync_ok);
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({bitslip, sync_ok, dout_valid, kout, dout} !== 12'h000) begin
      n_bad++;
      $display("FAIL mid_outputs: got %h, required 000", {bitslip, sync_ok, dout_valid, kout, dout});
    end
    n_total++;
    if ({err_cnt, los_cnt} !== 24'h0) begin
      n_bad++;
      $display("FAIL mid_stats: got err_cnt=%0d los_cnt=%0d, required 0 0", err_cnt, los_cnt);
    end
    exp_q.delete();
    p_d = '0; p_k = 1'b0; p_ce = 1'b0; p_de = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);
    n_total++;
    if (sync_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_los: got %b, required 0", sync_ok);
    end
    comma(1'b0); comma(1'b0); comma(1'b0);
    idle(2);
    n_total++;
    if (sync_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reacq: got %b, required 1", sync_ok);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_slip();
    test_err_recover();
    test_lose_sync();
    test_acq_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
